// File: rtl/shifter_pkg.sv
// Shared types for the pipelined shifter: operation encoding, per-stage control
// payload and the shift-amount width helper.
package shifter_pkg;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } sh_op_t;

  // Control half of the stage payload. Data and remaining shamt travel beside it
  // because their widths follow WIDTH.
  typedef struct packed {
    sh_op_t op;
    logic   carry;
    logic   fill;
  } sh_ctl_t;

  function automatic int shw(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One slice of the log shifter: NUM_LVL combinational levels starting at
// FIRST_LVL, followed by an elastic register with valid/ready.
module shift_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int FIRST_LVL = 0,
  parameter int NUM_LVL   = 1,
  parameter int SHW       = shw(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic [SHW-1:0]   i_shamt,
  input  sh_ctl_t          i_ctl,
  output logic             o_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_data,
  output logic [SHW-1:0]   o_shamt,
  output sh_ctl_t          o_ctl
);

  logic [WIDTH-1:0] w_data;
  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [SHW-1:0]   r_shamt;
  sh_ctl_t          r_ctl;

  // LSR and ASR share a path: the fill bit already carries the sign for ASR.
  always_comb begin
    w_data = i_data;
    for (int l = 0; l < NUM_LVL; l++) begin
      int amt;
      amt = 1 << (FIRST_LVL + l);
      if (i_shamt[FIRST_LVL+l]) begin
        case (i_ctl.op)
          SH_LSL:  w_data = w_data << amt;
          SH_ROR:  w_data = (w_data >> amt) | (w_data << (WIDTH - amt));
          default: w_data = (w_data >> amt) | ({WIDTH{i_ctl.fill}} << (WIDTH - amt));
        endcase
      end
    end
  end

  assign o_in_ready = !r_valid || i_out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_shamt <= '0;
      r_ctl   <= '0;
    end else if (o_in_ready) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data  <= w_data;
        r_shamt <= i_shamt;
        r_ctl   <= i_ctl;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_shamt = r_shamt;
  assign o_ctl   = r_ctl;

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined LSL/LSR/ASR/ROR/RRX shifter with ARM carry-out. Carry and RRX are
// resolved up front; the log levels are then spread over STAGES elastic slices.
module pipelined_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 1
) (
  input  logic                   CLK,
  input  logic                   Reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             Sh,
  input  logic [shw(WIDTH)-1:0]  Shamt,
  input  logic [WIDTH-1:0]       ShIn,
  input  logic                   CarryIn,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       ShOut,
  output logic                   CarryOut
);

  localparam int SHW   = shw(WIDTH);
  localparam int BASE  = SHW / STAGES;
  localparam int EXTRA = SHW % STAGES;

  sh_op_t           w_op;
  logic             w_nz;
  logic [SHW-1:0]   w_nm1;
  logic [SHW-1:0]   w_wmn;
  logic [WIDTH-1:0] w_data0;
  sh_ctl_t          w_ctl0;

  assign w_op  = sh_op_t'(Sh);
  assign w_nz  = |Shamt;
  assign w_nm1 = Shamt - SHW'(1);
  assign w_wmn = '0 - Shamt;  // WIDTH-n, valid for n != 0

  // RRX is finished here; with shamt 0 the levels below pass it through.
  always_comb begin
    w_data0     = ShIn;
    w_ctl0.op   = w_op;
    w_ctl0.fill = (w_op == SH_ASR) && ShIn[WIDTH-1];
    w_ctl0.carry = CarryIn;
    if (!w_nz) begin
      if (w_op == SH_ROR) begin
        w_data0      = {CarryIn, ShIn[WIDTH-1:1]};
        w_ctl0.carry = ShIn[0];
      end
    end else if (w_op == SH_LSL) begin
      w_ctl0.carry = ShIn[w_wmn];
    end else begin
      w_ctl0.carry = ShIn[w_nm1];
    end
  end

  logic [STAGES:0]            vld_pipe;
  logic [STAGES:0]            rdy_pipe;
  logic [STAGES:0][WIDTH-1:0] w_data;
  logic [STAGES:0][SHW-1:0]   w_shamt;
  sh_ctl_t [STAGES:0]         w_ctl;

  assign vld_pipe[0]      = in_valid;
  assign w_data[0]        = w_data0;
  assign w_shamt[0]       = Shamt;
  assign w_ctl[0]         = w_ctl0;
  assign rdy_pipe[STAGES] = out_ready;
  assign in_ready         = rdy_pipe[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int FIRST = k * BASE + ((k < EXTRA) ? k : EXTRA);
    localparam int NUM   = BASE + ((k < EXTRA) ? 1 : 0);
    shift_stage #(
      .WIDTH(WIDTH), .FIRST_LVL(FIRST), .NUM_LVL(NUM), .SHW(SHW)
    ) u_stage (
      .clk        (CLK),
      .rst_n      (Reset_n),
      .i_valid    (vld_pipe[k]),
      .o_in_ready (rdy_pipe[k]),
      .i_data     (w_data[k]),
      .i_shamt    (w_shamt[k]),
      .i_ctl      (w_ctl[k]),
      .o_valid    (vld_pipe[k+1]),
      .i_out_ready(rdy_pipe[k+1]),
      .o_data     (w_data[k+1]),
      .o_shamt    (w_shamt[k+1]),
      .o_ctl      (w_ctl[k+1])
    );
  end

  assign out_valid = vld_pipe[STAGES];
  assign ShOut     = w_data[STAGES];
  assign CarryOut  = w_ctl[STAGES].carry;

  logic w_unused;
  assign w_unused = ^{w_shamt[STAGES], w_ctl[STAGES].op, w_ctl[STAGES].fill};

endmodule

// File: tb/tb_pipelined_shifter.sv
// Bench for pipelined_shifter: directed ops, backpressure, mid-flight reset and
// random traffic on a 32/2 and an 8/3 instance, scored against a shift model.
module tb_pipelined_shifter;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic        a_iv, a_ir, a_ov, a_or, a_ci, a_co;
  logic [1:0]  a_sh;
  logic [4:0]  a_n;
  logic [31:0] a_x, a_y;

  logic        b_iv, b_ir, b_ov, b_or, b_ci, b_co;
  logic [1:0]  b_sh;
  logic [2:0]  b_n;
  logic [7:0]  b_x, b_y;

  pipelined_shifter #(.WIDTH(32), .STAGES(2)) u_a (
    .CLK(CLK), .Reset_n(rst_n), .in_valid(a_iv), .in_ready(a_ir), .Sh(a_sh),
    .Shamt(a_n), .ShIn(a_x), .CarryIn(a_ci), .out_valid(a_ov), .out_ready(a_or),
    .ShOut(a_y), .CarryOut(a_co));

  pipelined_shifter #(.WIDTH(8), .STAGES(3)) u_b (
    .CLK(CLK), .Reset_n(rst_n), .in_valid(b_iv), .in_ready(b_ir), .Sh(b_sh),
    .Shamt(b_n), .ShIn(b_x), .CarryIn(b_ci), .out_valid(b_ov), .out_ready(b_or),
    .ShOut(b_y), .CarryOut(b_co));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: ARM shifter rules on a w-bit word, returns {carry, result}.
  function automatic logic [32:0] model(input int w, input logic [1:0] op, input int n,
                                        input logic [31:0] x, input logic c);
    longint unsigned mask, xl, r;
    logic co;
    mask = (64'd1 << w) - 64'd1;
    xl   = {32'd0, x} & mask;
    if (n == 0) begin
      if (op == 2'b11) begin
        r  = ({63'd0, c} << (w - 1)) | (xl >> 1);
        co = xl[0];
      end else begin
        r  = xl;
        co = c;
      end
    end else begin
      case (op)
        2'b00: begin r = (xl << n) & mask; co = xl[w-n]; end
        2'b01: begin r = xl >> n; co = xl[n-1]; end
        2'b10: begin
          r = xl >> n;
          if (xl[w-1]) r = r | (mask & ~(mask >> n));
          co = xl[n-1];
        end
        default: begin r = ((xl >> n) | (xl << (w - n))) & mask; co = r[w-1]; end
      endcase
    end
    return {co, r[31:0]};
  endfunction

  logic [32:0] qa[$];
  logic [32:0] qb[$];
  int a_emit = 0;
  int b_emit = 0;

  // Scoreboards: every held or emitted output must match the oldest accepted request.
  always @(negedge CLK) begin
    if (rst_n) begin
      if (a_iv && a_ir) qa.push_back(model(32, a_sh, int'(a_n), a_x, a_ci));
      if (a_ov) begin
        if (qa.size() == 0) chk("A_spurious_out", a_ov, 0);
        else begin
          chk(a_or ? "A_result" : "A_stalled_result", {a_co, a_y}, qa[0]);
          if (a_or) begin void'(qa.pop_front()); a_emit++; end
        end
      end
      if (b_iv && b_ir) qb.push_back(model(8, b_sh, int'(b_n), {24'd0, b_x}, b_ci));
      if (b_ov) begin
        if (qb.size() == 0) chk("B_spurious_out", b_ov, 0);
        else begin
          chk(b_or ? "B_result" : "B_stalled_result", {b_co, 24'd0, b_y}, qb[0]);
          if (b_or) begin void'(qb.pop_front()); b_emit++; end
        end
      end
    end
  end

  task automatic send_a(input string tag, input logic [1:0] op, input logic [4:0] n,
                        input logic [31:0] x, input logic c, input logic [32:0] exp);
    int cyc;
    @(posedge CLK); #1;
    a_iv = 1; a_sh = op; a_n = n; a_x = x; a_ci = c; a_or = 1;
    @(posedge CLK); #1;
    a_iv = 0;
    cyc = 1;
    while (!a_ov && cyc < 20) begin @(posedge CLK); #1; cyc++; end
    chk({tag, "_latency"}, cyc, 2);
    chk({tag, "_out"}, {a_co, a_y}, exp);
  endtask

  task automatic send_b(input string tag, input logic [1:0] op, input logic [2:0] n,
                        input logic [7:0] x, input logic c, input logic [8:0] exp);
    int cyc;
    @(posedge CLK); #1;
    b_iv = 1; b_sh = op; b_n = n; b_x = x; b_ci = c; b_or = 1;
    @(posedge CLK); #1;
    b_iv = 0;
    cyc = 1;
    while (!b_ov && cyc < 20) begin @(posedge CLK); #1; cyc++; end
    chk({tag, "_latency"}, cyc, 3);
    chk({tag, "_out"}, {b_co, b_y}, exp);
  endtask

  initial begin
    int idx, cyc, e0;
    logic acc;
    rst_n = 0;
    a_iv = 0; a_sh = 0; a_n = 0; a_x = 0; a_ci = 0; a_or = 1;
    b_iv = 0; b_sh = 0; b_n = 0; b_x = 0; b_ci = 0; b_or = 1;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_A_out_valid", a_ov, 0);
    chk("rst_A_ShOut", a_y, 0);
    chk("rst_A_CarryOut", a_co, 0);
    chk("rst_B_out_valid", b_ov, 0);
    @(negedge CLK); rst_n = 1; #1;
    chk("rst_A_in_ready", a_ir, 1);
    chk("rst_B_in_ready", b_ir, 1);

    send_a("lsl1",   2'b00, 5'd1,  32'h8000_0001, 1'b0, {1'b1, 32'h0000_0002});
    send_a("asr31",  2'b10, 5'd31, 32'h8000_0000, 1'b0, {1'b0, 32'hFFFF_FFFF});
    send_a("lsr5",   2'b01, 5'd5,  32'h0000_00F0, 1'b0, {1'b1, 32'h0000_0007});
    send_a("ror4",   2'b11, 5'd4,  32'h0000_00F0, 1'b1, {1'b0, 32'h0000_000F});
    send_a("rrx",    2'b11, 5'd0,  32'h0000_0003, 1'b1, {1'b1, 32'h8000_0001});
    send_a("lsl0",   2'b00, 5'd0,  32'h1234_5678, 1'b0, {1'b0, 32'h1234_5678});
    send_a("asr0",   2'b10, 5'd0,  32'h8765_4321, 1'b1, {1'b1, 32'h8765_4321});
    send_b("w8_lsl7", 2'b00, 3'd7, 8'h81, 1'b1, {1'b0, 8'h80});
    send_b("w8_rrx",  2'b11, 3'd0, 8'h02, 1'b1, {1'b0, 8'h81});

    // Backpressure: six requests offered back to back, consumer stalled 4 cycles.
    a_or = 0; idx = 0; cyc = 0; e0 = a_emit;
    @(posedge CLK); #1;
    while (idx < 6 && cyc < 50) begin
      a_or = (cyc >= 4);
      a_iv = 1; a_sh = 2'(idx); a_n = 5'(3 * idx + 1); a_x = 32'hA5C3_0F17 ^ (32'h1111_1111 * idx);
      a_ci = idx[0];
      @(negedge CLK);
      if (cyc == 2) begin
        chk("bp_in_ready_full", a_ir, 0);
        chk("bp_accepts_before_full", idx, 2);
      end
      acc = a_ir;
      @(posedge CLK); #1;
      if (acc) idx++;
      cyc++;
    end
    chk("bp_all_accepted", idx, 6);
    a_iv = 0; a_or = 1;
    cyc = 0;
    while (qa.size() != 0 && cyc < 20) begin @(posedge CLK); #1; cyc++; end
    chk("bp_all_emitted", a_emit - e0, 6);
    chk("bp_queue_empty", qa.size(), 0);

    // Reset with two requests in flight.
    a_or = 0;
    @(posedge CLK); #1;
    a_iv = 1; a_sh = 2'b01; a_n = 5'd3; a_x = 32'hDEAD_BEEF;
    @(posedge CLK); #1;
    a_sh = 2'b00; a_n = 5'd9; a_x = 32'hCAFE_F00D;
    @(posedge CLK); #1;
    a_iv = 0;
    #2 rst_n = 0;
    #1;
    chk("midrst_out_valid", a_ov, 0);
    chk("midrst_ShOut", a_y, 0);
    chk("midrst_CarryOut", a_co, 0);
    qa.delete(); qb.delete();
    @(negedge CLK); rst_n = 1; #1;
    chk("midrst_in_ready", a_ir, 1);
    a_or = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      chk("midrst_no_stale", a_ov, 0);
    end

    // Random traffic with random stalls on both configurations.
    for (int i = 0; i < 600; i++) begin
      @(posedge CLK); #1;
      a_iv = ($urandom_range(0, 9) < 7); a_sh = 2'($urandom); a_n = 5'($urandom);
      a_x = $urandom; a_ci = 1'($urandom); a_or = ($urandom_range(0, 3) != 0);
      b_iv = ($urandom_range(0, 9) < 7); b_sh = 2'($urandom); b_n = 3'($urandom);
      b_x = 8'($urandom); b_ci = 1'($urandom); b_or = ($urandom_range(0, 3) != 0);
      if (i % 16 == 0) begin a_n = 0; b_n = 0; end
    end
    @(posedge CLK); #1;
    a_iv = 0; b_iv = 0; a_or = 1; b_or = 1;
    cyc = 0;
    while ((qa.size() != 0 || qb.size() != 0) && cyc < 20) begin @(posedge CLK); #1; cyc++; end
    chk("rand_A_drained", qa.size(), 0);
    chk("rand_B_drained", qb.size(), 0);
    chk("rand_A_out_idle", a_ov, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
